// File: rtl/core_pkg.sv
// Shared core types and defaults for the fetch front end.
// Holds the IF/ID bundle layout and the fetch NOP word.
package core_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, instr} skid FIFO between instruction memory and decode.
// Wrapping 1-bit pointers; clear empties it in one cycle.
module fetch_skid_fifo
  import core_pkg::*;
#(
  parameter int AW = core_pkg::ADDR_W,
  parameter int DW = core_pkg::INSTR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [AW-1:0] push_pc,
  input  logic [DW-1:0] push_instr,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [AW-1:0] head_pc,
  output logic [DW-1:0] head_instr
);

  logic [AW-1:0] pc_q  [2];
  logic [DW-1:0] ins_q [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt_q;
  logic          do_pop;
  logic          do_push;

  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (cnt_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_q[wr_ptr]  <= push_pc;
      ins_q[wr_ptr] <= push_instr;
    end
  end

  assign count      = cnt_q;
  assign head_pc    = pc_q[rd_ptr];
  assign head_instr = ins_q[rd_ptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst || clear)
    !(do_push && !do_pop && cnt_q == 2'd2)
  ) else $error("fetch fifo overflow");

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC handshake -> 1-cycle imem -> skid FIFO -> IF/ID.
// Optional perf counters under `FETCH_PERF_CNT_EN.
module instr_fetch_stage
  import core_pkg::*;
#(
  parameter int ADDR_W  = core_pkg::ADDR_W,
  parameter int INSTR_W = core_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR =
    core_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               pc_valid_i,
  output logic               pc_ready_o,
  input  logic               flush_i,
  output logic               imem_en_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_id_valid_o,
  input  logic               if_id_ready_i,
  output logic [ADDR_W-1:0]  if_id_pc_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        perf_stall_cnt_o,
  output logic [15:0]        perf_flush_cnt_o,
`endif
  output logic [INSTR_W-1:0] if_id_instr_o
);

  logic              infl_v;
  logic [ADDR_W-1:0] infl_pc;
  logic [1:0]        count;
  logic [ADDR_W-1:0] head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic              pop;
  logic              accept;
  logic              push;
  logic [2:0]        credit;

  assign pop    = if_id_valid_o & if_id_ready_i;
  assign accept = pc_valid_i & pc_ready_o;
  assign push   = infl_v & ~flush_i;

  // Slots committed after this edge: FIFO + in-flight - leaving.
  assign credit = {1'b0, count} + {2'b0, infl_v}
                - {2'b0, pop};

  assign pc_ready_o = ~rst & ~flush_i
                    & (credit < 3'd2);

  assign imem_en_o   = accept;
  assign imem_addr_o = pc_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      infl_v <= 1'b0;
    end else begin
      infl_v <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) infl_pc <= pc_i;
  end

  fetch_skid_fifo #(
    .AW (ADDR_W),
    .DW (INSTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush_i),
    .push       (push),
    .push_pc    (infl_pc),
    .push_instr (imem_rdata_i),
    .pop        (pop),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  assign if_id_valid_o = (count != 2'd0);
  assign if_id_pc_o    = if_id_valid_o ? head_pc : '0;
  assign if_id_instr_o = if_id_valid_o ? head_instr
                                       : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
  logic stall_ev;

  assign stall_ev = pc_valid_i & ~pc_ready_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_o <= 16'd0;
      perf_flush_cnt_o <= 16'd0;
    end else begin
      if (stall_ev && perf_stall_cnt_o != 16'hFFFF)
        perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
      if (flush_i && perf_flush_cnt_o != 16'hFFFF)
        perf_flush_cnt_o <= perf_flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: stream, stall, flush,
// wrap, mid-stream reset and (with the macro) perf counters.
module tb_instr_fetch_stage;
  import core_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_W-1:0]  pc_i = '0;
  logic               pc_valid_i = 1'b0;
  logic               pc_ready_o;
  logic               flush_i = 1'b0;
  logic               imem_en_o;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i = '0;
  logic               if_id_valid_o;
  logic               if_id_ready_i = 1'b0;
  logic [ADDR_W-1:0]  if_id_pc_o;
  logic [INSTR_W-1:0] if_id_instr_o;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        perf_stall_cnt_o;
  logic [15:0]        perf_flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .flush_i       (flush_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_ready_i (if_id_ready_i),
    .if_id_pc_o    (if_id_pc_o),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
    .if_id_instr_o (if_id_instr_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en_o)
      imem_rdata_i <= 32'hA000_0000 + 32'(imem_addr_o);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v,
                       input int p, input logic rdy,
                       input logic f);
    @(negedge clk);
    rst = r;
    pc_valid_i = v;
    pc_i = ADDR_W'(p);
    if_id_ready_i = rdy;
    flush_i = f;
    #1;
  endtask

  task automatic chk_head(input string tag, input int p);
    if_id_t e;
    e.pc = ADDR_W'(p);
    e.instr = 32'hA000_0000 + 32'(p);
    check(tag, {if_id_valid_o, if_id_pc_o, if_id_instr_o},
          {1'b1, e});
  endtask

  task automatic chk_empty(input string tag);
    check(tag, {if_id_valid_o, if_id_pc_o, if_id_instr_o},
          {1'b0, ADDR_W'(0), 32'h0000_0013});
  endtask

  initial begin
    int nxt;
    int expn;
    int cyc;
    logic acc;

    // reset
    drive(1, 0, 0, 0, 0);
    check("rst_ready", pc_ready_o, 0);
    drive(1, 1, 0, 1, 0);
    check("rst_ready_v", pc_ready_o, 0);
    check("rst_en", imem_en_o, 0);
    chk_empty("rst_out");

    // streaming
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, k, 1, 0);
      if (k == 0) begin
        check("first_ready", pc_ready_o, 1);
        check("first_en", {imem_en_o, imem_addr_o},
              {1'b1, 5'd0});
      end
      if (k == 1) chk_empty("latency_gap");
      if (k >= 2) chk_head("stream", k - 2);
    end

    // backpressure
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8, 0, 0);
      check("stall_ready", pc_ready_o, 0);
      chk_head("stall_head", 6);
    end
    check("stall_full", dut.u_fifo.count, 2);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8 + k, 1, 0);
      chk_head("drain", 6 + k);
    end

    // flush with count=1 and one in flight
    drive(0, 1, 12, 1, 1);
    check("flush_ready", {pc_ready_o, imem_en_o}, 0);
    chk_head("flush_old", 10);
    drive(0, 1, 12, 1, 0);
    chk_empty("post_flush");
    check("resume_ready", pc_ready_o, 1);
    drive(0, 1, 13, 1, 0);
    chk_empty("late_dropped");
    drive(0, 1, 14, 1, 0);
    chk_head("resume", 12);
    drive(0, 0, 0, 1, 0);
    chk_head("resume1", 13);
    drive(0, 0, 0, 1, 0);
    chk_head("resume2", 14);
    drive(0, 0, 0, 1, 0);
    chk_empty("resume_empty");

    // wrap-around with alternating ready
    drive(1, 0, 0, 0, 0);
    nxt = 3;
    expn = 3;
    cyc = 0;
    while (expn < 8 && cyc < 40) begin
      drive(0, nxt <= 7, nxt, cyc[0], 0);
      acc = pc_valid_i & pc_ready_o;
      if (if_id_valid_o && if_id_ready_i) begin
        chk_head("wrap", expn);
        expn++;
      end
      if (acc) nxt++;
      cyc++;
    end
    check("wrap_count", expn, 8);

    // reset with FIFO full
    drive(0, 1, 20, 0, 0);
    check("fill0", pc_ready_o, 1);
    drive(0, 1, 21, 0, 0);
    check("fill1", pc_ready_o, 1);
    drive(0, 1, 22, 0, 0);
    check("fill2", pc_ready_o, 0);
    drive(0, 1, 22, 0, 0);
    chk_head("full_head", 20);
    drive(1, 1, 22, 0, 0);
    check("rst_mid_in", {pc_ready_o, imem_en_o}, 0);
    drive(1, 1, 22, 1, 0);
    chk_empty("rst_mid_out");
    check("rst_mid_ready", pc_ready_o, 0);
    drive(0, 1, 24, 1, 0);
    check("rst_resume", pc_ready_o, 1);
    drive(0, 0, 0, 1, 0);
    chk_empty("no_stale");
    drive(0, 0, 0, 1, 0);
    chk_head("after_rst", 24);

`ifdef FETCH_PERF_CNT_EN
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("perf_rst", {perf_stall_cnt_o, perf_flush_cnt_o}, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, i, 0, 0);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("perf_stall", perf_stall_cnt_o, 3);
    check("perf_flush", perf_flush_cnt_o, 2);
    for (int i = 0; i < 65540; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("perf_sat", perf_stall_cnt_o, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly downstream of the program counter.
- Accepts a PC through a valid/ready handshake and issues it to a synchronous instruction memory with 1-cycle read latency.
- Buffers the returned word in a 2-entry skid FIFO and presents {pc, instr} to decode through the IF/ID valid/ready handshake.
- Supports flush on branch/redirect and sustains 1 instruction/cycle when decode never stalls.

Parameters:
ADDR_W, 5, PC / instruction-memory address width
INSTR_W, 32, instruction word width
NOP_INSTR, 32'h0000_0013, word driven on if_id_instr_o when no valid entry

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pc_i  in  ADDR_W  PC from program counter
pc_valid_i  in  1  pc_i is valid
pc_ready_o  out  1  fetch can accept pc_i this cycle (PC holds when low)
flush_i  in  1  kill all buffered and in-flight fetches
imem_en_o  out  1  memory read enable
imem_addr_o  out  ADDR_W  memory read address
imem_rdata_i  in  INSTR_W  memory data, valid the cycle after imem_en_o
if_id_valid_o  out  1  entry available to decode
if_id_ready_i  in  1  decode accepts the entry
if_id_pc_o  out  ADDR_W  PC of the presented instruction
if_id_instr_o  out  INSTR_W  presented instruction

Behaviour:
- State:
  - 2-entry FIFO of {pc, instr} with wrapping 1-bit rd/wr pointers and a 2-bit count.
  - In-flight register {infl_v, infl_pc}.
- Definitions:
  - pop = if_id_valid_o & if_id_ready_i.
  - accept = pc_valid_i & pc_ready_o.
- pc_ready_o = !flush_i & ((count + infl_v - pop) < 2).
  - This is an intentional combinational path from if_id_ready_i and flush_i.
- Memory interface: imem_en_o = accept; imem_addr_o = pc_i (combinational).
- Clock edge with accept: infl_v <= 1 and infl_pc <= pc_i. Otherwise infl_v <= 0.
- Clock edge with infl_v = 1 and no flush: push {infl_pc, imem_rdata_i} into the FIFO.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Capacity: push never overflows, guaranteed by the pc_ready_o credit rule. An overflow is an assertion failure.
- Output: if_id_valid_o = (count != 0); pc and instr come from the FIFO head.
  - When count = 0: if_id_pc_o = 0 and if_id_instr_o = NOP_INSTR.
- Latency: PC accepted in cycle N gives the entry visible on IF/ID in cycle N+2.
- Throughput: 1 per cycle with if_id_ready_i held high.
- Stall: with if_id_ready_i low, the FIFO fills (2 entries).
  - pc_ready_o drops once count + infl_v = 2.
  - Head outputs stay stable while valid and not popped.
- Flush (highest priority):
  - At the edge, count <= 0, pointers <= 0, infl_v <= 0.
  - The memory response arriving next cycle for a request accepted before the flush is discarded.
  - No accept in the flush cycle.
  - The pop in the flush cycle is ignored: if_id_valid_o still shows the old head, but decode must treat flush as a kill.
  - Fetch resumes the cycle after flush deasserts.
- Reset (sync, high):
  - count = 0, pointers = 0, infl_v = 0.
  - Outputs: if_id_valid_o 0, if_id_pc_o 0, if_id_instr_o NOP_INSTR, imem_en_o 0.
  - pc_ready_o 0 during reset.
  - An in-flight response arriving in the cycle after reset is discarded.
- Reset mid-stream behaves identically to flush, plus the pointer clear.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_stall_cnt_o[15:0] and perf_flush_cnt_o[15:0].
  - perf_stall_cnt_o counts cycles with pc_valid_i & !pc_ready_o & !flush_i.
  - perf_flush_cnt_o counts cycles with flush_i.
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - ADDR_W and INSTR_W defaults
  - NOP_INSTR constant
  - if_id_t struct {pc, instr}
- One sub-module: fetch_skid_fifo (2-entry {pc, instr} FIFO with push/pop/clear/count). The top level holds the in-flight register, credit logic and perf counters.

Test Plan:
- Streaming: reset, then pc_valid_i high with pc_i = 0,1,2,… and if_id_ready_i = 1; memory returns 32'hA000_0000 + addr. Expect first valid at cycle 2, then one entry/cycle, {pc=k, instr=A000_000k}, no bubbles.
- Backpressure: stream as above, drop if_id_ready_i for 4 cycles. Expect count to reach 2 and pc_ready_o to drop; head pc stays stable. On release, entries drain in order with none lost or duplicated.
- Flush with in-flight: flush_i pulse while count = 1 and infl_v = 1. Expect if_id_valid_o = 0 and if_id_instr_o = 32'h0000_0013 next cycle. The late memory word is discarded, and the first post-flush PC appears 2 cycles after its accept.
- Wrap-around: push/pop 5 entries with alternating ready. Expect pointers to wrap and order to be preserved (pc 3,4,5,6,7).
- Reset mid-operation: assert rst with FIFO full. Next cycle, expect all outputs at reset values and pc_ready_o = 0. The response for the last accepted PC never appears.
- With FETCH_PERF_CNT_EN: 3 stall cycles and 2 flushes. Expect perf_stall_cnt_o = 3 and perf_flush_cnt_o = 2; a forced 65 536 stalls reads 16'hFFFF.
